// File: rtl/rocketcpu_dbg_pkg.sv
// rocketcpu_dbg_pkg: shared constants and state types for the serial debug Wishbone bridge.
package rocketcpu_dbg_pkg;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_TO  = 8'h54;
    localparam logic [7:0] RSP_ERR = 8'h3F;
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RESP, ST_RDAT} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/rocketcpu_dbg_uart_phy.sv
// rocketcpu_dbg_uart_phy: 8N1 serial receiver and transmitter, LSB first.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   rx_i                : asynchronous serial input, idle high
//   rx_byte_o/rx_valid_o: received byte, valid for one cycle when its stop bit is high
//   tx_o                : registered serial output, idle high
//   tx_byte_i/tx_start_i: byte to send, accepted while tx_busy_o is low
//   tx_busy_o           : high from start until the stop bit has ended
module rocketcpu_dbg_uart_phy
    import rocketcpu_dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_start_i,
    output logic       tx_busy_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    // [0],[1] synchronise; [2] is the previous synchronised level for edge detection
    logic [2:0] sync_q;
    rx_state_t rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic rx_valid_q, rx_valid_d, tx_q, tx_d, tx_busy_q, tx_busy_d;
    logic [8:0] tx_sh_q, tx_sh_d;
    logic [3:0] tx_idx_q, tx_idx_d;
    logic rx_s, rx_prev;
    assign rx_s       = sync_q[1];
    assign rx_prev    = sync_q[2];
    assign rx_byte_o  = rx_sh_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_o       = tx_q;
    assign tx_busy_o  = tx_busy_q;
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) rx_st_d = RX_START;
            end
            // a start bit that is high again at half bit was a glitch
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == FULL) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == FULL) begin
                rx_valid_d = rx_s;
                rx_st_d    = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end
    // tx_sh_q holds the remaining data bits with the stop bit above them
    always_comb begin
        tx_d      = tx_q;
        tx_sh_d   = tx_sh_q;
        tx_idx_d  = tx_idx_q;
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q + 1'b1;
        if (!tx_busy_q) begin
            tx_cnt_d = '0;
            if (tx_start_i) begin
                tx_busy_d = 1'b1;
                tx_d      = 1'b0;
                tx_sh_d   = {1'b1, tx_byte_i};
                tx_idx_d  = '0;
            end
        end else if (tx_cnt_q == FULL) begin
            tx_cnt_d  = '0;
            tx_idx_d  = tx_idx_q + 4'd1;
            tx_d      = tx_sh_q[0];
            tx_sh_d   = {1'b1, tx_sh_q[8:1]};
            tx_busy_d = tx_idx_q != 4'd9;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 3'b111;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_sh_q    <= '1;
            tx_idx_q   <= '0;
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], rx_i};
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            tx_q       <= tx_d;
            tx_sh_q    <= tx_sh_d;
            tx_idx_q   <= tx_idx_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_busy_q  <= tx_busy_d;
        end
    end
endmodule

// File: rtl/rocketcpu_uart_wb_master.sv
// rocketcpu_uart_wb_master: serial debug commands become single 32-bit Wishbone read/write cycles.
//   i_wb_clk, i_wb_rst_n : clock, asynchronous active-low reset
//   i_dbg_rx, o_dbg_tx   : host serial line, 8N1, idle high
//   o_wb_adr/dat/sel/we/cyc, i_wb_rdt/ack : Wishbone initiator port (cyc doubles as stb)
//   o_busy               : high from the first command byte until the last reply byte has left
module rocketcpu_uart_wb_master
    import rocketcpu_dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_dbg_rx,
    output logic        o_dbg_tx,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_busy
);
    state_t state_q, state_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdt_q, rdt_d;
    logic [15:0] to_q, to_d;
    logic [7:0] resp_q, resp_d, rx_byte;
    logic [1:0] cnt_q, cnt_d;
    logic we_q, we_d, rd_ok_q, rd_ok_d, sent_q, sent_d, busy_q, busy_d;
    logic rx_valid, tx_start, tx_busy, tx_done;
    rocketcpu_dbg_uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk_i      (i_wb_clk),
        .rst_ni     (i_wb_rst_n),
        .rx_i       (i_dbg_rx),
        .tx_o       (o_dbg_tx),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .tx_byte_i  (state_q == ST_RDAT ? rdt_q[31:24] : resp_q),
        .tx_start_i (tx_start),
        .tx_busy_o  (tx_busy)
    );
    // sent_q marks a byte handed to the PHY; its busy flag rises on the same edge
    assign tx_done  = sent_q && !tx_busy;
    assign o_wb_cyc = state_q == ST_BUS;
    assign o_wb_sel = {4{o_wb_cyc}};
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_we  = we_q;
    assign o_busy   = busy_q;
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rdt_d    = rdt_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        to_d     = '0;
        resp_d   = resp_q;
        rd_ok_d  = rd_ok_q;
        sent_d   = sent_q;
        busy_d   = busy_q;
        tx_start = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_valid) begin
                busy_d  = 1'b1;
                cnt_d   = '0;
                sent_d  = 1'b0;
                rd_ok_d = 1'b0;
                resp_d  = RSP_ERR;
                we_d    = rx_byte == CMD_WR;
                state_d = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ST_ADDR : ST_RESP;
            end
            ST_ADDR: if (rx_valid) begin
                adr_d = {adr_q[23:0], rx_byte};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = we_q ? ST_DATA : ST_BUS;
            end
            ST_DATA: if (rx_valid) begin
                dat_d = {dat_q[23:0], rx_byte};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ST_BUS;
            end
            // ack wins over the timeout when both land on the same edge
            ST_BUS: begin
                to_d = to_q + 16'd1;
                if (i_wb_ack) begin
                    state_d = ST_RESP;
                    resp_d  = RSP_OK;
                    rd_ok_d = !we_q;
                    if (!we_q) rdt_d = i_wb_rdt;
                end else if (to_q == 16'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                    resp_d  = RSP_TO;
                end
            end
            ST_RESP, ST_RDAT: begin
                tx_start = !sent_q;
                sent_d   = 1'b1;
                if (tx_done) begin
                    sent_d = 1'b0;
                    if (state_q == ST_RDAT) begin
                        rdt_d = {rdt_q[23:0], 8'h00};
                        cnt_d = cnt_q + 2'd1;
                    end
                    if (state_q == ST_RESP && rd_ok_q) begin
                        state_d = ST_RDAT;
                        cnt_d   = '0;
                    end else if (state_q == ST_RESP || cnt_q == 2'd3) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            rdt_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            to_q    <= '0;
            resp_q  <= '0;
            rd_ok_q <= 1'b0;
            sent_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdt_q   <= rdt_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            resp_q  <= resp_d;
            rd_ok_q <= rd_ok_d;
            sent_q  <= sent_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_rocketcpu_uart_wb_master.sv
// tb_rocketcpu_uart_wb_master: table-driven and scoreboard bench for the serial Wishbone bridge.
module tb_rocketcpu_uart_wb_master;
    localparam int CPB = 16;
    typedef struct {
        logic [71:0] cmd;
        int          ncmd;
        int          dly;
        logic [31:0] rdt;
        bit          bus;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          len;
        logic [39:0] rsp;
        int          nrsp;
    } vec_t;
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          len;
    } bus_t;
    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    logic tx, we, cyc, busy, ack;
    logic [31:0] adr, dat, rdt_val = '0;
    logic [3:0] sel;
    int checks = 0, errors = 0;
    int ack_delay = -1, cyc_len = 0, cyc_no = 0, stop_mid_cyc = 0, idle_cyc = 0;
    bit in_cyc = 0, stable = 0;
    logic [31:0] c_adr, c_dat;
    logic c_we;
    logic [7:0] mon_b;
    logic [7:0] rsp_q[$];
    bus_t bus_q[$];
    bus_t be;
    vec_t vecs[8];
    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;
    // slave acks in cyc cycle number ack_delay (0 = same cycle); -1 never acks
    assign ack = cyc && ack_delay >= 0 && cyc_len == ack_delay + 1;
    rocketcpu_uart_wb_master #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(1024)) dut (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_dbg_rx(rx), .o_dbg_tx(tx),
        .o_wb_adr(adr), .o_wb_dat(dat), .o_wb_sel(sel), .o_wb_we(we), .o_wb_cyc(cyc),
        .i_wb_rdt(rdt_val), .i_wb_ack(ack), .o_busy(busy)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask
    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_q.size() != 0 || bus_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        idle_cyc = cyc_no;
        chk("idle_wait", n < 20000, 1);
        chk("busy_end", busy, 0);
        chk("cyc_end", cyc, 0);
    endtask
    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.nrsp; i++) rsp_q.push_back(v.rsp[39-8*i -: 8]);
        if (v.bus) bus_q.push_back('{v.adr, v.dat, v.we, v.len});
        ack_delay = v.dly;
        rdt_val   = v.rdt;
        for (int i = 0; i < v.ncmd; i++) send_byte(v.cmd[71-8*i -: 8], 1'b1);
        wait_idle();
    endtask
    // bus monitor: checks each completed cycle against the expected-cycle queue
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_cyc  = 0;
            cyc_len = 0;
        end else if (cyc) begin
            if (!in_cyc) begin
                in_cyc = 1;
                c_adr  = adr;
                c_dat  = dat;
                c_we   = we;
                stable = 1;
            end
            cyc_len++;
            if (adr !== c_adr || dat !== c_dat || we !== c_we || sel !== 4'hF) stable = 0;
        end else if (in_cyc) begin
            in_cyc = 0;
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: cycle of %0d clocks at adr %08h, none expected", cyc_len, c_adr);
            end else begin
                be = bus_q.pop_front();
                chk("cyc_len", cyc_len, be.len);
                chk("bus_adr", c_adr, be.adr);
                chk("bus_we", c_we, be.we);
                if (be.we) chk("bus_dat", c_dat, be.dat);
                chk("bus_stable_sel", stable, 1);
            end
            cyc_len = 0;
        end
    end
    // tx monitor: decodes reply bytes and pops the expected-reply queue
    initial forever begin
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            chk("tx_start_bit", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            stop_mid_cyc = cyc_no;
            chk("tx_stop_bit", tx, 1);
            chk("busy_in_stop", busy, 1);
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got byte %02h, none expected", mon_b);
            end else chk("tx_byte", mon_b, rsp_q.pop_front());
        end
    end
    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
    initial begin
        int n, d;
        vecs[0] = '{{8'h57, 32'h00000010, 32'hDEADBEEF}, 9, 2, 32'h0, 1'b1, 32'h00000010, 32'hDEADBEEF, 1'b1, 3, {8'h4B, 32'h0}, 1};
        vecs[1] = '{{8'h52, 32'h02000000, 32'h0}, 5, 0, 32'h00000001, 1'b1, 32'h02000000, 32'h0, 1'b0, 1, {8'h4B, 32'h00000001}, 5};
        vecs[2] = '{{8'h52, 32'h10000000, 32'h0}, 5, -1, 32'h0, 1'b1, 32'h10000000, 32'h0, 1'b0, 1024, {8'h54, 32'h0}, 1};
        vecs[3] = '{{8'h52, 32'h00000020, 32'h0}, 5, 1, 32'hCAFEF00D, 1'b1, 32'h00000020, 32'h0, 1'b0, 2, {8'h4B, 32'hCAFEF00D}, 5};
        vecs[4] = '{{8'hA5, 32'h0, 32'h0}, 1, 0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0, {8'h3F, 32'h0}, 1};
        vecs[5] = '{{8'h57, 32'h12345678, 32'h000000FF}, 9, 0, 32'h0, 1'b1, 32'h12345678, 32'h000000FF, 1'b1, 1, {8'h4B, 32'h0}, 1};
        vecs[6] = '{{8'h52, 32'h00000100, 32'h0}, 5, 1023, 32'h5A5AA5A5, 1'b1, 32'h00000100, 32'h0, 1'b0, 1024, {8'h4B, 32'h5A5AA5A5}, 5};
        vecs[7] = '{{8'h52, 32'h00000008, 32'h0}, 5, 1, 32'h0BADF00D, 1'b1, 32'h00000008, 32'h0, 1'b0, 2, {8'h4B, 32'h0BADF00D}, 5};
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_cyc", cyc, 0);
        chk("rst_we", we, 0);
        chk("rst_sel", sel, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 7; k++) run_vec(vecs[k]);
        send_byte(8'h52, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        chk("framing_busy", busy, 0);
        rx = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk("glitch_busy", busy, 0);
        run_vec(vecs[4]);
        // overrun: bytes arriving during BUS and RESP must be dropped
        rsp_q.push_back(8'h4B);
        rsp_q.push_back(8'h11);
        rsp_q.push_back(8'h22);
        rsp_q.push_back(8'h33);
        rsp_q.push_back(8'h44);
        bus_q.push_back('{32'h00000040, 32'h0, 1'b0, 301});
        ack_delay = 300;
        rdt_val = 32'h11223344;
        chk("busy_before_cmd", busy, 0);
        send_byte(8'h52, 1'b1);
        chk("busy_first_byte", busy, 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h57, 1'b1);
        wait_idle();
        d = idle_cyc - stop_mid_cyc;
        chk("busy_fall_timing", d >= CPB / 2 && d <= CPB / 2 + 2, 1);
        chk("tx_idle_after", tx, 1);
        run_vec(vecs[4]);
        // reset while a cycle is outstanding
        ack_delay = -1;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        n = 0;
        while (!cyc && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("cyc_before_reset", cyc, 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", cyc, 0);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_adr", adr, 0);
        chk("mid_rst_we", we, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_vec(vecs[7]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
